// File: rtl/aes_pkg.sv
// ---------------------------------------------------------------------------
// aes_pkg
// Shared types and helpers for the AES round sequencer slice.
//   state_t            : 4x4 AES state, byte [r][c] holds FIPS byte 4c+r
//   AES_NUM_ROUNDS_128 : round count for AES-128
//   seq_state_t        : sequencer FSM states
//   fipsToState()      : converts a 128-bit FIPS byte stream (byte 0 in the
//                        MSBs) into the row/column state layout
// ---------------------------------------------------------------------------
package aes_pkg;

    typedef logic [3:0][3:0][7:0] state_t;

    localparam int AES_NUM_ROUNDS_128 = 10;

    typedef enum logic [2:0] {
        IDLE,
        SUB,
        DIFF,
        ARK,
        DONE
    } seq_state_t;

    // FIPS-197 lists the state column by column, so stream byte n lands in
    // row n%4, column n/4.
    function automatic state_t fipsToState(input logic [127:0] bytes);
        state_t s;
        for (int r = 0; r < 4; r++) begin
            for (int c = 0; c < 4; c++) begin
                s[r][c] = bytes[127 - 8*(4*c + r) -: 8];
            end
        end
        return s;
    endfunction

endpackage

// File: rtl/aes_add_round_key.sv
// ---------------------------------------------------------------------------
// aes_add_round_key
// Combinational AddRoundKey: output state is the input state XOR the key.
// Ports:
//   i_state    : state to be keyed
//   i_roundKey : round key from the external key store
//   o_state    : keyed state
// ---------------------------------------------------------------------------
module aes_add_round_key
    import aes_pkg::*;
(
    input  state_t i_state,
    input  state_t i_roundKey,
    output state_t o_state
);

    assign o_state = i_state ^ i_roundKey;

endmodule

// File: rtl/aes_round_sequencer.sv
// ---------------------------------------------------------------------------
// aes_round_sequencer
// Multi-cycle AES round controller. Time-multiplexes external SubBytes and
// ShiftRows/MixColumns blocks over a single state register, walks the round
// counter and requests round keys from an external key store.
// Optional build macro: ROUND_TRACE_EN adds o_trace_valid/o_trace_round.
// Ports:
//   i_clk, i_reset     : clock, asynchronous active-high reset
//   i_start / o_ready  : host request, accepted only while ready
//   i_plaintext        : input block, sampled on the accepting edge
//   o_key_idx          : round-key index (nonzero only in ARK)
//   i_round_key        : key for o_key_idx, valid in the same cycle
//   o_confusion_in     : state to SubBytes; i_confusion_out its result
//   o_diffusion_in     : state to ShiftRows(+MixColumns)
//   i_diffusion_out    : ShiftRows+MixColumns result
//   i_srows_out        : ShiftRows-only result (last round)
//   o_ciphertext       : registered result, held until the next completion
//   o_done             : one-cycle completion pulse
//   o_trace_valid/o_trace_round : per-round trace (ROUND_TRACE_EN only)
// ---------------------------------------------------------------------------
module aes_round_sequencer
    import aes_pkg::*;
#(
    parameter int NUM_ROUNDS = AES_NUM_ROUNDS_128,
    parameter int KEY_IDX_W  = 4
) (
    input  logic                 i_clk,
    input  logic                 i_reset,
    input  logic                 i_start,
    output logic                 o_ready,
    input  state_t               i_plaintext,
    output logic [KEY_IDX_W-1:0] o_key_idx,
    input  state_t               i_round_key,
    output state_t               o_confusion_in,
    input  state_t               i_confusion_out,
    output state_t               o_diffusion_in,
    input  state_t               i_diffusion_out,
    input  state_t               i_srows_out,
    output state_t               o_ciphertext,
    output logic                 o_done
`ifdef ROUND_TRACE_EN
    ,
    output logic                 o_trace_valid,
    output logic [KEY_IDX_W-1:0] o_trace_round
`endif
);

    localparam logic [KEY_IDX_W-1:0] LAST_ROUND = KEY_IDX_W'(NUM_ROUNDS);
    localparam logic [KEY_IDX_W-1:0] ROUND_ONE  = KEY_IDX_W'(1);

    seq_state_t             r_fsm;
    seq_state_t             w_fsmNext;
    logic [KEY_IDX_W-1:0]   r_round;
    state_t                 r_state;
    state_t                 r_ciphertext;
    state_t                 w_arkIn;
    state_t                 w_arkOut;
    logic                   w_lastRound;

    assign w_lastRound = (r_round == LAST_ROUND);

    // One AddRoundKey instance serves both the initial whitening in IDLE
    // (plaintext ^ key 0) and every ARK step (state ^ key[round]).
    assign w_arkIn = (r_fsm == IDLE) ? i_plaintext : r_state;

    aes_add_round_key u_addRoundKey (
        .i_state    (w_arkIn),
        .i_roundKey (i_round_key),
        .o_state    (w_arkOut)
    );

    assign o_confusion_in = r_state;
    assign o_diffusion_in = r_state;
    assign o_ciphertext   = r_ciphertext;

    // FSM state register.
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            r_fsm <= IDLE;
        end else begin
            r_fsm <= w_fsmNext;
        end
    end

    // Next-state logic: SUB -> DIFF -> ARK repeats once per round, and the
    // last ARK leaves for DONE instead of starting another round.
    always_comb begin
        w_fsmNext = r_fsm;
        case (r_fsm)
            IDLE:    if (i_start) w_fsmNext = SUB;
            SUB:     w_fsmNext = DIFF;
            DIFF:    w_fsmNext = ARK;
            ARK:     w_fsmNext = w_lastRound ? DONE : SUB;
            DONE:    w_fsmNext = IDLE;
            default: w_fsmNext = IDLE;
        endcase
    end

    // Output decode. The key index is only the round number during ARK;
    // everywhere else it requests key 0 so IDLE can whiten the plaintext.
    always_comb begin
        o_ready   = (r_fsm == IDLE);
        o_done    = (r_fsm == DONE);
        o_key_idx = (r_fsm == ARK) ? r_round : '0;
    end

    // Datapath: the state register takes whichever transform the current
    // phase selects; the last round uses ShiftRows without MixColumns.
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            r_state      <= '0;
            r_round      <= '0;
            r_ciphertext <= '0;
        end else begin
            case (r_fsm)
                IDLE: begin
                    if (i_start) begin
                        r_state <= w_arkOut;
                        r_round <= ROUND_ONE;
                    end
                end
                SUB:  r_state <= i_confusion_out;
                DIFF: r_state <= w_lastRound ? i_srows_out : i_diffusion_out;
                ARK: begin
                    r_state <= w_arkOut;
                    if (w_lastRound) begin
                        r_ciphertext <= w_arkOut;
                    end else begin
                        r_round <= r_round + ROUND_ONE;
                    end
                end
                default: ;
            endcase
        end
    end

`ifdef ROUND_TRACE_EN
    logic                 r_traceValid;
    logic [KEY_IDX_W-1:0] r_traceRound;

    // Flags the cycle after each ARK edge; r_state then holds the
    // post-round state, visible on o_diffusion_in.
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            r_traceValid <= 1'b0;
            r_traceRound <= '0;
        end else begin
            r_traceValid <= (r_fsm == ARK);
            if (r_fsm == ARK) begin
                r_traceRound <= r_round;
            end
        end
    end

    assign o_trace_valid = r_traceValid;
    assign o_trace_round = r_traceRound;
`endif

endmodule

// File: doc/aes_round_sequencer.md
Name: aes_round_sequencer

Overview:
Multi-cycle controller that runs a 4x4 byte AES state through NUM_ROUNDS cipher rounds. It time-multiplexes the existing combinational confusion (SubBytes) and diffusion (ShiftRows+MixColumns, plus ShiftRows-only tap) blocks, and owns the state register, round counter and round-key index. It sits between the host start/done handshake and an external round-key store.

Parameters:
NUM_ROUNDS, 10, cipher rounds executed; the last round skips MixColumns. Legal range 1-14.
KEY_IDX_W, 4, width of key_idx; must satisfy 2**KEY_IDX_W > NUM_ROUNDS.

Ports:
clk  in  1  single clock, rising-edge.
reset  in  1  asynchronous, active-high; clears all state.
start  in  1  request; sampled only while ready=1.
ready  out  1  high in IDLE.
plaintext  in  [7:0] [3:0][3:0]  input state, row/col indexed; byte [r][c] = FIPS byte 4c+r.
key_idx  out  KEY_IDX_W  round-key index requested from the key store.
round_key  in  [7:0] [3:0][3:0]  key for key_idx, combinationally valid in the same cycle.
confusion_in  out  [7:0] [3:0][3:0]  driven from the state register.
confusion_out  in  [7:0] [3:0][3:0]  SubBytes result.
diffusion_in  out  [7:0] [3:0][3:0]  driven from the state register.
diffusion_out  in  [7:0] [3:0][3:0]  ShiftRows+MixColumns result.
srows_out  in  [7:0] [3:0][3:0]  ShiftRows-only result.
ciphertext  out  [7:0] [3:0][3:0]  registered result, held until the next completion.
done  out  1  one-cycle pulse; ciphertext valid from this cycle on.

Behaviour:
- Reset values: FSM=IDLE, round=0, key_idx=0, state=0, ciphertext=0, done=0, ready=1.
- FSM states: IDLE, SUB, DIFF, ARK, DONE.
- IDLE: key_idx=0. On an edge with start=1, load state <= plaintext ^ round_key (key 0), set round <= 1 and go to SUB.
- SUB: state <= confusion_out; go to DIFF.
- DIFF: state <= (round==NUM_ROUNDS) ? srows_out : diffusion_out; go to ARK.
- ARK: key_idx=round, state <= state ^ round_key.
  - If round==NUM_ROUNDS: ciphertext <= state ^ round_key; go to DONE.
  - Otherwise: round <= round+1; go to SUB.
- DONE: done=1 for exactly this cycle. Go to IDLE; ready rises on the next cycle.
- key_idx is combinational from FSM and round. It equals 0 outside ARK.
- Latency: start accepted at edge E0; ciphertext and done valid in the cycle after edge E(3*NUM_ROUNDS), i.e. 30 cycles for 10 rounds. Throughput is one block per 3*NUM_ROUNDS+2 cycles.
- start while ready=0 is ignored, with no queuing. start held high re-triggers on the first IDLE edge after DONE.
- plaintext is sampled only at the accepting edge; later changes have no effect.
- Reset asserted mid-operation aborts immediately to reset values; the partial result is discarded and done is not pulsed.
- round never exceeds NUM_ROUNDS. round is KEY_IDX_W wide and has no wrap-around.

Optional Feature:
ROUND_TRACE_EN: adds outputs trace_valid (1 bit) and trace_round (KEY_IDX_W bits).
- trace_valid pulses in the cycle after every ARK edge, with trace_round equal to the just-completed round number (1..NUM_ROUNDS).
- In that cycle, diffusion_in shows the post-round state.
- Both outputs reset to 0.
- Without the macro, these ports and their logic do not exist; core timing is identical either way.

Decomposition:
Package aes_pkg:
- state_t typedef ([7:0] [3:0][3:0])
- AES_NUM_ROUNDS_128=10
- seq_state_t enum {IDLE,SUB,DIFF,ARK,DONE}
- helper function for FIPS byte-order to state_t conversion.

Sub-module: aes_add_round_key, a combinational state XOR key, instantiated once and shared by the IDLE load and ARK.

Test Plan:
- FIPS-197 App. B: plaintext 3243f6a8885a308d313198a2e0370734, key 2b7e151628aed2a6abf7158809cf4f3c, key-store model holds the expanded keys. Pulse start -> done exactly 30 cycles later; ciphertext=3925841d02dc09fbdc118597196a0b32; key_idx steps 1..10, one value per ARK.
- Reset pulse at cycle 12 of an operation -> ready=1 and ciphertext=0 next cycle, no done; a fresh start then gives the correct result.
- start asserted at cycles 5 and 20 during an operation -> ignored, exactly one done pulse.
- start held high continuously -> done pulses spaced 32 cycles apart; ciphertext stable between pulses.
- plaintext changed one cycle after the accepting edge -> result still matches the originally sampled plaintext.
- With ROUND_TRACE_EN: trace_valid pulses 10 times, trace_round = 1..10; the round-1 state matches FIPS App. B (a49c7ff2689f352b6b5bea43026a5049).
